// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
// Module   : instruction_fetch_pkg
// Brief    : Shared widths, halt word and FSM encoding for the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package instruction_fetch_pkg;

    localparam int c_PC_WIDTH    = 64;
    localparam int c_INSTR_WIDTH = 32;

    localparam logic [c_INSTR_WIDTH-1:0] c_HALT_WORD = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
// Module   : fetch_pc_reg
// Brief    : Program counter with word-aligned load, increment and hold.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [c_PC_WIDTH-1:0] i_load_pc,
    input  logic                  i_inc,
    output logic [c_PC_WIDTH-1:0] o_pc
);

    localparam logic [c_PC_WIDTH-1:0] c_STEP = 64'(PC_STEP);

    logic [c_PC_WIDTH-1:0] r_pc;

    // Load wins over increment; increment wraps modulo 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc & ~64'h3;
        end else if (i_inc) begin
            r_pc <= r_pc + c_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage: PC, IF/ID register with valid/ready, redirect, halt.
//            Optional perf counters enabled by FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          PC_STEP      = 4,
    parameter int          HALT_ON_ZERO = 1
) (
    input  logic                     CLK,
    input  logic                     Reset_L,
    output logic [c_PC_WIDTH-1:0]    ImemAddress,
    input  logic [c_INSTR_WIDTH-1:0] ImemData,
    input  logic                     Redirect,
    input  logic [c_PC_WIDTH-1:0]    RedirectPC,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [c_INSTR_WIDTH-1:0] OutInstr,
    output logic [c_PC_WIDTH-1:0]    OutPC,
    output logic                     Halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              FetchCount,
    output logic [31:0]              StallCount
`endif
);

    fetch_state_t              r_state;
    logic                      r_out_valid;
    logic [c_INSTR_WIDTH-1:0]  r_out_instr;
    logic [c_PC_WIDTH-1:0]     r_out_pc;
    logic [c_PC_WIDTH-1:0]     w_pc;

    logic w_in_fetch;
    logic w_accept;
    logic w_halt_word;
    logic w_load_out;

    assign w_in_fetch  = (r_state == ST_FETCH);
    assign w_accept    = !r_out_valid || OutReady;
    assign w_halt_word = (HALT_ON_ZERO != 0) && (ImemData == c_HALT_WORD);
    assign w_load_out  = w_in_fetch && !Redirect && w_accept && !w_halt_word;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .i_load    (Redirect),
        .i_load_pc (RedirectPC),
        .i_inc     (w_load_out),
        .o_pc      (w_pc)
    );

    // A transfer on the redirect edge still completes: decode samples the
    // old contents, the flush only clears valid for what follows.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state     <= ST_FETCH;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (Redirect) begin
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        if (w_halt_word) begin
                            r_state     <= ST_HALT;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_instr <= ImemData;
                            r_out_pc    <= w_pc;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (Redirect) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = w_in_fetch && r_out_valid && !OutReady && !Redirect;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_load_out && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign FetchCount = r_fetch_cnt;
    assign StallCount = r_stall_cnt;
`endif

    assign ImemAddress = w_pc;
    assign OutValid    = r_out_valid;
    assign OutInstr    = r_out_instr;
    assign OutPC       = r_out_pc;
    assign Halted      = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Vector table, corner sequences and randomized model check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    logic        clk;
    logic        rst_l;
    logic        use_rand;
    logic [31:0] rmem [64];
    logic [31:0] pat  [4] = '{32'hD2E24689, 32'hD2CACF0B, 32'hD2B3578C, 32'hD29BDE0D};

    logic [63:0] addr1, rpc1, opc1, addr2, rpc2, opc2;
    logic [31:0] data1, instr1, data2, instr2;
    logic        redir1, ready1, valid1, halt1;
    logic        redir2, ready2, valid2, halt2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc1, sc1, fc2, sc2;
`endif

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] imem(input logic [63:0] a, input logic rnd);
        if (rnd) return (a[63:8] == 56'h0) ? rmem[a[7:2]] : 32'h0;
        return (a < 64'h20) ? pat[a[3:2]] : 32'h0;
    endfunction

    assign data1 = imem(addr1, use_rand);
    assign data2 = imem(addr2, 1'b0);

    instruction_fetch #(.RESET_PC(64'h0), .PC_STEP(4), .HALT_ON_ZERO(1)) dut1 (
        .CLK(clk), .Reset_L(rst_l), .ImemAddress(addr1), .ImemData(data1),
        .Redirect(redir1), .RedirectPC(rpc1), .OutValid(valid1), .OutReady(ready1),
        .OutInstr(instr1), .OutPC(opc1), .Halted(halt1)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(fc1), .StallCount(sc1)
`endif
    );

    instruction_fetch #(.RESET_PC(64'h0), .PC_STEP(4), .HALT_ON_ZERO(0)) dut2 (
        .CLK(clk), .Reset_L(rst_l), .ImemAddress(addr2), .ImemData(data2),
        .Redirect(redir2), .RedirectPC(rpc2), .OutValid(valid2), .OutReady(ready2),
        .OutInstr(instr2), .OutPC(opc2), .Halted(halt2)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(fc2), .StallCount(sc2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        redir;
        logic [63:0] rpc;
        logic        ready;
        logic        ev;
        logic [31:0] ei;
        logic [63:0] ep;
        logic        eh;
        logic [63:0] ea;
        int unsigned efc;
        int unsigned esc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [63:0] t, input logic rd,
                                input logic v, input logic [31:0] i, input logic [63:0] p,
                                input logic h, input logic [63:0] a,
                                input int unsigned f, input int unsigned s);
        vec_t x;
        x.redir = r; x.rpc = t; x.ready = rd; x.ev = v; x.ei = i; x.ep = p;
        x.eh = h; x.ea = a; x.efc = f; x.esc = s;
        return x;
    endfunction

    // Behavioural view of the stage: what decode sees and where fetch points.
    typedef struct {
        logic [63:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [63:0] opc;
        logic        halted;
        int unsigned fc;
        int unsigned sc;
    } model_t;

    function automatic model_t step(input model_t m, input logic rd, input logic [63:0] t,
                                    input logic rdy, input logic [31:0] d);
        model_t n = m;
        if (rd) begin
            n.pc = {t[63:2], 2'b00};
            n.halted = 1'b0;
            if (!m.halted) n.valid = 1'b0;
        end else if (!m.halted) begin
            if (m.valid && !rdy) begin
                if (n.sc != 32'hFFFF_FFFF) n.sc++;
            end else if (d == 32'h0) begin
                n.halted = 1'b1;
                n.valid  = 1'b0;
            end else begin
                n.instr = d;
                n.opc   = m.pc;
                n.valid = 1'b1;
                n.pc    = m.pc + 64'd4;
                if (n.fc != 32'hFFFF_FFFF) n.fc++;
            end
        end
        return n;
    endfunction

    initial begin
        vec_t   vecs[$];
        model_t m;

        rst_l = 1'b0; use_rand = 1'b0;
        redir1 = 1'b0; rpc1 = '0; ready1 = 1'b1;
        redir2 = 1'b0; rpc2 = '0; ready2 = 1'b1;
        for (int i = 0; i < 64; i++) rmem[i] = ($urandom_range(9) == 0) ? 32'h0 : $urandom;

        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 0, 1, 1, pat[(k-1)%4], 64'((k-1)*4), 0, 64'(k*4), k, 0));
        vecs.push_back(mk(0, 0,     1, 0, 32'hD29BDE0D, 64'h1C, 1, 64'h20, 8, 0));
        vecs.push_back(mk(0, 0,     1, 0, 32'hD29BDE0D, 64'h1C, 1, 64'h20, 8, 0));
        vecs.push_back(mk(1, 0,     1, 0, 32'hD29BDE0D, 64'h1C, 0, 64'h00, 8, 0));
        vecs.push_back(mk(0, 0,     1, 1, 32'hD2E24689, 64'h00, 0, 64'h04, 9, 0));
        vecs.push_back(mk(0, 0,     1, 1, 32'hD2CACF0B, 64'h04, 0, 64'h08, 10, 0));
        for (int s = 1; s <= 3; s++)
            vecs.push_back(mk(0, 0, 0, 1, 32'hD2CACF0B, 64'h04, 0, 64'h08, 10, s));
        vecs.push_back(mk(0, 0,     1, 1, 32'hD2B3578C, 64'h08, 0, 64'h0C, 11, 3));
        vecs.push_back(mk(0, 0,     0, 1, 32'hD2B3578C, 64'h08, 0, 64'h0C, 11, 4));
        vecs.push_back(mk(1, 64'h13, 0, 0, 32'hD2B3578C, 64'h08, 0, 64'h10, 11, 4));
        vecs.push_back(mk(0, 0,     0, 1, 32'hD2E24689, 64'h10, 0, 64'h14, 12, 4));

        #2;
        chk("reset valid", 64'(valid1), 64'h0);
        chk("reset instr", 64'(instr1), 64'h0);
        chk("reset outpc", opc1, 64'h0);
        chk("reset halted", 64'(halt1), 64'h0);
        chk("reset addr", addr1, 64'h0);
        tick();
        rst_l = 1'b1;

        foreach (vecs[i]) begin
            redir1 = vecs[i].redir; rpc1 = vecs[i].rpc; ready1 = vecs[i].ready;
            tick();
            chk($sformatf("v%0d valid", i),  64'(valid1), 64'(vecs[i].ev));
            chk($sformatf("v%0d instr", i),  64'(instr1), 64'(vecs[i].ei));
            chk($sformatf("v%0d outpc", i),  opc1,        vecs[i].ep);
            chk($sformatf("v%0d halted", i), 64'(halt1),  64'(vecs[i].eh));
            chk($sformatf("v%0d addr", i),   addr1,       vecs[i].ea);
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("v%0d fetchcnt", i), 64'(fc1), 64'(vecs[i].efc));
            chk($sformatf("v%0d stallcnt", i), 64'(sc1), 64'(vecs[i].esc));
`endif
        end

        // Asynchronous reset between edges while stalled.
        redir1 = 1'b0; ready1 = 1'b0;
        tick();
        chk("stall hold valid", 64'(valid1), 64'h1);
        chk("stall hold addr", addr1, 64'h14);
        #3 rst_l = 1'b0;
        #1;
        chk("async rst valid", 64'(valid1), 64'h0);
        chk("async rst halted", 64'(halt1), 64'h0);
        chk("async rst addr", addr1, 64'h0);
        chk("async rst instr", 64'(instr1), 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("async rst fetchcnt", 64'(fc1), 64'h0);
        chk("async rst stallcnt", 64'(sc1), 64'h0);
`endif
        tick();
        rst_l = 1'b1; ready1 = 1'b1;

        // Wrap through zero with zero words passed through (second instance).
        redir2 = 1'b1; rpc2 = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        chk("wrap redirect addr", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap redirect valid", 64'(valid2), 64'h0);
        redir2 = 1'b0;
        tick();
        chk("wrap zero word valid", 64'(valid2), 64'h1);
        chk("wrap zero word instr", 64'(instr2), 64'h0);
        chk("wrap zero word outpc", opc2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap zero word halted", 64'(halt2), 64'h0);
        chk("wrap addr 0", addr2, 64'h0);
        tick();
        chk("wrap next instr", 64'(instr2), 64'hD2E24689);
        chk("wrap next outpc", opc2, 64'h0);
        chk("wrap addr 4", addr2, 64'h4);

        // Randomized run against the model.
        #2 rst_l = 1'b0;
        use_rand = 1'b1;
        tick();
        rst_l = 1'b1;
        m = '{pc: 64'h0, valid: 1'b0, instr: 32'h0, opc: 64'h0, halted: 1'b0, fc: 0, sc: 0};
        for (int c = 0; c < 400; c++) begin
            redir1 = ($urandom_range(7) == 0);
            rpc1   = 64'($urandom_range(255));
            ready1 = ($urandom_range(3) != 0);
            m = step(m, redir1, rpc1, ready1, imem(m.pc, 1'b1));
            tick();
            chk($sformatf("r%0d valid", c),  64'(valid1), 64'(m.valid));
            chk($sformatf("r%0d halted", c), 64'(halt1),  64'(m.halted));
            chk($sformatf("r%0d addr", c),   addr1,       m.pc);
            if (m.valid) begin
                chk($sformatf("r%0d instr", c), 64'(instr1), 64'(m.instr));
                chk($sformatf("r%0d outpc", c), opc1,        m.opc);
            end
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("r%0d fetchcnt", c), 64'(fc1), 64'(m.fc));
            chk($sformatf("r%0d stallcnt", c), 64'(sc1), 64'(m.sc));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage that sits directly upstream of InstructionMemory.
- Owns the program counter (PC) and drives the memory's 64-bit byte address.
- Captures the returned 32-bit word into an IF/ID output register with a valid/ready handshake toward decode.
- Handles branch redirect/flush, back-pressure stalls, and halt on an all-zero (unprogrammed) instruction word.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- HALT_ON_ZERO, 1, when 1 an ImemData of 32'h00000000 halts fetch; when 0 it is passed on as a normal word.

Ports:
- CLK  input  1  single clock; all state on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- ImemAddress  output  64  byte address to InstructionMemory; always equals PC.
- ImemData  input  32  combinational instruction word returned for ImemAddress.
- Redirect  input  1  branch/exception redirect request (single-cycle pulse or held).
- RedirectPC  input  64  target PC; bits [1:0] are forced to 0 on load.
- OutValid  output  1  IF/ID register holds a valid instruction.
- OutReady  input  1  decode accepts; a transfer occurs on an edge where OutValid && OutReady.
- OutInstr  output  32  registered instruction word.
- OutPC  output  64  PC of OutInstr.
- Halted  output  1  high while in HALT state.

Behaviour:
- Reset (Reset_L low, asynchronous):
  - PC=RESET_PC, state=FETCH.
  - OutValid=0, OutInstr=0, OutPC=0, Halted=0.
- Address path: ImemAddress=PC, combinational from the PC register. Memory is combinational, so fetch latency is 1 cycle: a word fetched at PC appears on OutInstr/OutPC after the next rising edge.
- Accept condition: accept = !OutValid || OutReady.
- States: FETCH and HALT.
- FETCH, per edge, in priority order:
  1. Redirect=1: PC<=RedirectPC&~3, OutValid<=0 (flush), state stays FETCH. The current ImemData is discarded. If OutValid&&OutReady on the same edge, that transfer completes (decode sampled it) and the flush affects only what follows.
  2. accept=1 and HALT_ON_ZERO=1 and ImemData==0: state<=HALT, OutValid<=0, PC holds (Halted then reads the halting address via ImemAddress).
  3. accept=1: OutInstr<=ImemData, OutPC<=PC, OutValid<=1, PC<=PC+PC_STEP.
  4. accept=0 (stall): PC, OutInstr, OutPC, OutValid hold. Data must stay stable while OutValid && !OutReady.
- HALT:
  - Halted=1, no fetches, PC holds.
  - Any pending OutValid already cleared by the halt transition.
  - Redirect=1: PC<=RedirectPC&~3, state<=FETCH, Halted<=0.
- PC arithmetic: unsigned 64-bit, wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
- Reset mid-stall or mid-halt returns immediately to reset values; no partial transfer survives.
- No combinational path from OutReady to OutValid/OutInstr; OutReady gates only register enables.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output FetchCount[31:0] and output StallCount[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - FetchCount increments on every edge where case 3 loads the output register.
  - StallCount increments on every FETCH edge with OutValid && !OutReady && !Redirect.
  - Both hold in HALT.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding (FETCH=1'b0, HALT=1'b1), PC width constant (64), instruction width (32), HALT_WORD (32'h0).
- One natural sub-module: fetch_pc_reg, holding the PC register with load/increment/hold select and reset to RESET_PC.
- The IF/ID register and FSM stay in instruction_fetch.

Test Plan:
- Release reset with RESET_PC=0, OutReady=1, InstructionMemory attached:
  - OutInstr sequence is D2E24689, D2CACF0B, D2B3578C, D29BDE0D, D2E24689, D2CACF0B, D2B3578C, D29BDE0D on consecutive cycles, with OutPC 0x0 through 0x1C in steps of 4.
  - At PC=0x20, ImemData=0, so Halted=1, OutValid=0, ImemAddress stays 0x20.
- Back-pressure: hold OutReady=0 for 3 cycles while OutInstr=D2CACF0B, OutPC=0x4.
  - Outputs and ImemAddress=0x8 stay stable.
  - After release, the next word is D2B3578C at 0x8, with no skip and no duplicate.
- Redirect to 0x13 while OutValid=1 and OutReady=0:
  - Next edge OutValid=0 and PC=0x10.
  - Following edge OutInstr=D2E24689, OutPC=0x10.
- Redirect during HALT with RedirectPC=0x0: Halted falls, and D2E24689 at 0x0 appears one edge later.
- Wrap: Redirect to 0xFFFF_FFFF_FFFF_FFFC with HALT_ON_ZERO=0 and OutReady=1: after two accepts, PC=0x4 (passes through 0x0).
- Assert Reset_L low asynchronously mid-stall (between edges):
  - OutValid, Halted and PC go to 0 without waiting for a clock edge.
  - With FETCH_PERF_CNT_EN defined, FetchCount and StallCount read 0, and stall counting matches the 3-cycle scenario (StallCount=3).
